// File: rtl/reorder_retire_ctrl_pkg.sv
// Shared types and constants for the reorder-buffer allocate/complete/retire controller.
// Optional check logic in the top level is enabled by REORDER_RETIRE_CTRL_CHECK_EN.
package reorder_retire_ctrl_pkg;

  localparam int unsigned TAG_W = 4;
  localparam int unsigned CNT_W = TAG_W + 1;
  localparam int unsigned DEPTH = 1 << TAG_W;

  typedef logic [TAG_W-1:0] tag_t;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam logic VQ_SET = 1'b1;
  localparam logic VQ_CLR = 1'b0;

  // Queue depth for a given tag width.
  function automatic int unsigned depth_of(input int unsigned aw);
    return 32'(1) << aw;
  endfunction

endpackage

// File: rtl/reorder_tag_ptr.sv
// Wrapping tag pointer with increment enable; wraps naturally at 2**WIDTH.
module reorder_tag_ptr
  import reorder_retire_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = TAG_W
) (
  input  logic             clock,
  input  logic             nrst,
  input  logic             inc,
  output logic [WIDTH-1:0] ptr
);

  always_ff @(posedge clock) begin
    if (!nrst) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + WIDTH'(1);
    end
  end

endmodule

// File: rtl/reorder_retire_ctrl.sv
// In-order allocate/complete/retire controller driving the ROB valid queue.
// Define REORDER_RETIRE_CTRL_CHECK_EN to reject and flag completions outside head..tail-1.
module reorder_retire_ctrl
  import reorder_retire_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = TAG_W
) (
  input  logic                  clock,
  input  logic                  nrst,
  input  logic                  alloc_req,
  output logic                  alloc_gnt,
  output logic [ADDR_WIDTH-1:0] alloc_tag,
  input  logic                  cpl_valid,
  input  logic [ADDR_WIDTH-1:0] cpl_tag,
  output logic                  cpl_ready,
  output logic                  ret_valid,
  output logic [ADDR_WIDTH-1:0] ret_tag,
  input  logic                  ret_ready,
  output logic                  vq_we,
  output logic [ADDR_WIDTH-1:0] vq_wraddr,
  output logic                  vq_wrdata,
  output logic [ADDR_WIDTH-1:0] vq_rdaddr,
  input  logic                  vq_q,
  output logic                  cpl_err
);

  localparam int unsigned   CW       = ADDR_WIDTH + 1;
  localparam int unsigned   QDEPTH   = depth_of(ADDR_WIDTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(QDEPTH);

  logic [ADDR_WIDTH-1:0] head;
  logic [ADDR_WIDTH-1:0] tail;
  logic [ADDR_WIDTH-1:0] head_inc;
  logic [ADDR_WIDTH-1:0] rd_tag_q;
  logic [ADDR_WIDTH-1:0] rdaddr;
  logic [CW-1:0]         count;
  logic                  grant;
  logic                  ret_ok;
  logic                  retire_fire;
  logic                  cpl_take;
  logic                  cpl_wr_ok;

  reorder_tag_ptr #(.WIDTH(ADDR_WIDTH)) u_head (
    .clock (clock),
    .nrst  (nrst),
    .inc   (retire_fire),
    .ptr   (head)
  );

  reorder_tag_ptr #(.WIDTH(ADDR_WIDTH)) u_tail (
    .clock (clock),
    .nrst  (nrst),
    .inc   (grant),
    .ptr   (tail)
  );

  // Handshake decode; the read port looks one entry ahead when the head retires.
  always_comb begin
    grant       = alloc_req && (count != FULL_CNT);
    ret_ok      = (count != '0) && (rd_tag_q == head) && vq_q;
    retire_fire = ret_ok && ret_ready;
    cpl_take    = cpl_valid && !retire_fire;
    head_inc    = head + ADDR_WIDTH'(1);
    rdaddr      = retire_fire ? head_inc : head;
  end

`ifdef REORDER_RETIRE_CTRL_CHECK_EN
  logic [ADDR_WIDTH-1:0] cpl_off;
  logic                  cpl_err_q;

  // Legal when the modular distance from head is inside the occupied window.
  always_comb begin
    cpl_off   = cpl_tag - head;
    cpl_wr_ok = (count != '0) && (CW'(cpl_off) < count);
  end

  always_ff @(posedge clock) begin
    if (!nrst) begin
      cpl_err_q <= 1'b0;
    end else if (cpl_take && !cpl_wr_ok) begin
      cpl_err_q <= 1'b1;
    end
  end

  assign cpl_err = nrst && cpl_err_q;
`else
  assign cpl_wr_ok = 1'b1;
  assign cpl_err   = 1'b0;
`endif

  // Single write port: retire-clear wins over completion-set.
  always_comb begin
    vq_we     = 1'b0;
    vq_wraddr = '0;
    vq_wrdata = VQ_CLR;
    if (nrst) begin
      if (retire_fire) begin
        vq_we     = 1'b1;
        vq_wraddr = head;
        vq_wrdata = VQ_CLR;
      end else if (cpl_take && cpl_wr_ok) begin
        vq_we     = 1'b1;
        vq_wraddr = cpl_tag;
        vq_wrdata = VQ_SET;
      end
    end
  end

  assign alloc_gnt = nrst && grant;
  assign alloc_tag = nrst ? tail : '0;
  assign cpl_ready = nrst && !retire_fire;
  assign ret_valid = nrst && ret_ok;
  assign ret_tag   = nrst ? head : '0;
  assign vq_rdaddr = nrst ? rdaddr : '0;

  // Occupancy and the address whose data arrives on vq_q next cycle.
  always_ff @(posedge clock) begin
    if (!nrst) begin
      count    <= '0;
      rd_tag_q <= '0;
    end else begin
      case ({grant, retire_fire})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      rd_tag_q <= rdaddr;
    end
  end

endmodule

// File: tb/tb_reorder_retire_ctrl.sv
// Scoreboard bench for reorder_retire_ctrl with a registered-read valid-queue model.
// The window-check scenario runs only when REORDER_RETIRE_CTRL_CHECK_EN is defined.
module tb_reorder_retire_ctrl;
  import reorder_retire_ctrl_pkg::*;

  localparam int unsigned N = 16;

  logic clock = 1'b0;
  logic nrst  = 1'b0;
  logic alloc_req = 1'b0;
  logic alloc_gnt;
  tag_t alloc_tag;
  logic cpl_valid = 1'b0;
  tag_t cpl_tag   = '0;
  logic cpl_ready;
  logic ret_valid;
  tag_t ret_tag;
  logic ret_ready = 1'b0;
  logic vq_we;
  tag_t vq_wraddr;
  logic vq_wrdata;
  tag_t vq_rdaddr;
  logic vq_q;
  logic cpl_err;

  int   total = 0;
  int   bad   = 0;
  tag_t sb[$];
  int   m_tail  = 0;
  int   m_count = 0;

  reorder_retire_ctrl #(.ADDR_WIDTH(4)) dut (
    .clock     (clock),
    .nrst      (nrst),
    .alloc_req (alloc_req),
    .alloc_gnt (alloc_gnt),
    .alloc_tag (alloc_tag),
    .cpl_valid (cpl_valid),
    .cpl_tag   (cpl_tag),
    .cpl_ready (cpl_ready),
    .ret_valid (ret_valid),
    .ret_tag   (ret_tag),
    .ret_ready (ret_ready),
    .vq_we     (vq_we),
    .vq_wraddr (vq_wraddr),
    .vq_wrdata (vq_wrdata),
    .vq_rdaddr (vq_rdaddr),
    .vq_q      (vq_q),
    .cpl_err   (cpl_err)
  );

  always #5 clock = ~clock;

  // Valid queue: synchronous reset, registered read returning pre-write data.
  logic vq_mem [N];
  always_ff @(posedge clock) begin
    if (!nrst) begin
      for (int i = 0; i < N; i++) vq_mem[i] <= 1'b0;
      vq_q <= 1'b0;
    end else begin
      if (vq_we) vq_mem[vq_wraddr] <= vq_wrdata;
      vq_q <= vq_mem[vq_rdaddr];
    end
  end

  task automatic drive(input logic req, input logic cv, input tag_t ct, input logic rr);
    alloc_req = req;
    cpl_valid = cv;
    cpl_tag   = ct;
    ret_ready = rr;
    @(negedge clock);
  endtask

  task automatic advance();
    @(posedge clock);
    #1;
  endtask

  // Bench-side occupancy model: grants push the expected retire order.
  task automatic note(input logic g, input logic f);
    if (g) begin
      sb.push_back(tag_t'(m_tail));
      m_tail = (m_tail + 1) % N;
    end
    if (g && !f) m_count++;
    if (f && !g) m_count--;
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    drive(1'b0, 1'b0, '0, 1'b0);
    advance();
    nrst = 1'b1;
    sb.delete();
    m_tail  = 0;
    m_count = 0;
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    for (int c = 0; c < 2; c++) begin
      drive(1'b1, 1'b1, tag_t'(3), 1'b1);
      total++; if (alloc_gnt !== 1'b0) begin bad++; $display("FAIL rst_gnt: got %b want 0", alloc_gnt); end
      total++; if (alloc_tag !== '0)   begin bad++; $display("FAIL rst_tag: got %0d want 0", alloc_tag); end
      total++; if (cpl_ready !== 1'b0) begin bad++; $display("FAIL rst_cpl_ready: got %b want 0", cpl_ready); end
      total++; if (ret_valid !== 1'b0) begin bad++; $display("FAIL rst_ret_valid: got %b want 0", ret_valid); end
      total++; if (vq_we !== 1'b0)     begin bad++; $display("FAIL rst_vq_we: got %b want 0", vq_we); end
      total++; if (vq_rdaddr !== '0)   begin bad++; $display("FAIL rst_rdaddr: got %0d want 0", vq_rdaddr); end
      total++; if (cpl_err !== 1'b0)   begin bad++; $display("FAIL rst_cpl_err: got %b want 0", cpl_err); end
      advance();
    end
    nrst = 1'b1;
    sb.delete();
    m_tail  = 0;
    m_count = 0;
    drive(1'b0, 1'b0, '0, 1'b0);
    total++; if (ret_valid !== 1'b0) begin bad++; $display("FAIL post_rst_ret_valid: got %b want 0", ret_valid); end
    total++; if (cpl_ready !== 1'b1) begin bad++; $display("FAIL post_rst_cpl_ready: got %b want 1", cpl_ready); end
    total++; if (alloc_tag !== '0)   begin bad++; $display("FAIL post_rst_tag: got %0d want 0", alloc_tag); end
    advance();
  endtask

  // 16 grants in tag order, then the 17th request is refused.
  task automatic test_fill();
    logic g;
    for (int i = 0; i <= N; i++) begin
      drive(1'b1, 1'b0, '0, 1'b0);
      g = (i < N);
      total++; if (alloc_gnt !== g) begin bad++; $display("FAIL fill_gnt[%0d]: got %b want %b", i, alloc_gnt, g); end
      total++; if (alloc_tag !== tag_t'(i % N)) begin bad++; $display("FAIL fill_tag[%0d]: got %0d want %0d", i, alloc_tag, i % N); end
      total++; if (ret_valid !== 1'b0) begin bad++; $display("FAIL fill_ret_valid[%0d]: got %b want 0", i, ret_valid); end
      advance();
      note(g, 1'b0);
    end
  endtask

  // Complete every entry, then stream retires with allocation held high across the wrap.
  task automatic test_full_stream();
    logic g, f;
    tag_t et;
    for (int i = 0; i < N; i++) begin
      drive(1'b0, 1'b1, tag_t'(i), 1'b0);
      total++; if (cpl_ready !== 1'b1) begin bad++; $display("FAIL fs_cpl_ready[%0d]: got %b want 1", i, cpl_ready); end
      total++; if ({vq_we, vq_wraddr, vq_wrdata} !== {1'b1, tag_t'(i), 1'b1})
        begin bad++; $display("FAIL fs_cpl_write[%0d]: got we=%b a=%0d d=%b want we=1 a=%0d d=1", i, vq_we, vq_wraddr, vq_wrdata, i); end
      total++; if (ret_valid !== (i >= 2)) begin bad++; $display("FAIL fs_ret_valid[%0d]: got %b want %b", i, ret_valid, i >= 2); end
      advance();
    end
    drive(1'b0, 1'b0, '0, 1'b0);
    advance();
    for (int c = 0; c < N + 2; c++) begin
      drive(1'b1, 1'b0, '0, 1'b1);
      f = (c < N);
      g = (m_count != N);
      total++; if (ret_valid !== f) begin bad++; $display("FAIL fs_stream_valid[%0d]: got %b want %b", c, ret_valid, f); end
      total++; if (alloc_gnt !== g) begin bad++; $display("FAIL fs_stream_gnt[%0d]: got %b want %b", c, alloc_gnt, g); end
      total++; if (alloc_tag !== tag_t'(m_tail)) begin bad++; $display("FAIL fs_stream_atag[%0d]: got %0d want %0d", c, alloc_tag, m_tail); end
      if (f) begin
        et = sb.pop_front();
        total++; if (ret_tag !== et) begin bad++; $display("FAIL fs_stream_rtag[%0d]: got %0d want %0d", c, ret_tag, et); end
        total++; if ({vq_we, vq_wraddr, vq_wrdata} !== {1'b1, et, 1'b0})
          begin bad++; $display("FAIL fs_stream_clear[%0d]: got we=%b a=%0d d=%b want a=%0d", c, vq_we, vq_wraddr, vq_wrdata, et); end
        total++; if (vq_rdaddr !== tag_t'(et + 1)) begin bad++; $display("FAIL fs_stream_rdaddr[%0d]: got %0d want %0d", c, vq_rdaddr, tag_t'(et + 1)); end
      end
      advance();
      note(g, f);
    end
  endtask

  // Reset with six tags outstanding discards them; allocation restarts at 0.
  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0, '0, 1'b0);
      advance();
      note(1'b1, 1'b0);
    end
    drive(1'b0, 1'b1, tag_t'(0), 1'b0); advance();
    drive(1'b0, 1'b1, tag_t'(1), 1'b0); advance();
    drive(1'b0, 1'b0, '0, 1'b0); advance();
    drive(1'b0, 1'b0, '0, 1'b0);
    total++; if (ret_valid !== 1'b1) begin bad++; $display("FAIL rm_pre_valid: got %b want 1", ret_valid); end
    total++; if (alloc_tag !== tag_t'(6)) begin bad++; $display("FAIL rm_pre_tail: got %0d want 6", alloc_tag); end
    advance();
    nrst = 1'b0;
    drive(1'b1, 1'b1, tag_t'(2), 1'b1);
    total++; if ({alloc_gnt, ret_valid, vq_we, cpl_ready} !== 4'b0000)
      begin bad++; $display("FAIL rm_in_reset: got gnt=%b rv=%b we=%b cr=%b want 0000", alloc_gnt, ret_valid, vq_we, cpl_ready); end
    advance();
    nrst = 1'b1;
    sb.delete();
    m_tail  = 0;
    m_count = 0;
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 1'b0, '0, 1'b1);
      total++; if (ret_valid !== 1'b0) begin bad++; $display("FAIL rm_post_valid[%0d]: got %b want 0", c, ret_valid); end
      total++; if (ret_tag !== '0) begin bad++; $display("FAIL rm_post_head[%0d]: got %0d want 0", c, ret_tag); end
      total++; if (alloc_tag !== '0) begin bad++; $display("FAIL rm_post_tail[%0d]: got %0d want 0", c, alloc_tag); end
      advance();
    end
    drive(1'b1, 1'b0, '0, 1'b0);
    total++; if ({alloc_gnt, alloc_tag} !== {1'b1, tag_t'(0)})
      begin bad++; $display("FAIL rm_restart: got gnt=%b tag=%0d want gnt=1 tag=0", alloc_gnt, alloc_tag); end
    advance();
    note(1'b1, 1'b0);
  endtask

  // Out-of-order completion 2,3,0,1; retire waits for tag 0 then streams 0..3.
  task automatic test_out_of_order();
    tag_t ord [4] = '{tag_t'(2), tag_t'(3), tag_t'(0), tag_t'(1)};
    logic f;
    tag_t et;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, '0, 1'b0);
      total++; if (alloc_tag !== tag_t'(i)) begin bad++; $display("FAIL ooo_atag[%0d]: got %0d want %0d", i, alloc_tag, i); end
      advance();
      note(1'b1, 1'b0);
    end
    for (int k = 0; k < 10; k++) begin
      if (k < 4) drive(1'b0, 1'b1, ord[k], 1'b1);
      else       drive(1'b0, 1'b0, '0, 1'b1);
      f = (k >= 4) && (k <= 7);
      total++; if (ret_valid !== f) begin bad++; $display("FAIL ooo_valid[%0d]: got %b want %b", k, ret_valid, f); end
      if (f) begin
        et = sb.pop_front();
        total++; if (ret_tag !== et) begin bad++; $display("FAIL ooo_rtag[%0d]: got %0d want %0d", k, ret_tag, et); end
        total++; if ({vq_we, vq_wraddr, vq_wrdata} !== {1'b1, et, 1'b0})
          begin bad++; $display("FAIL ooo_clear[%0d]: got we=%b a=%0d d=%b want a=%0d d=0", k, vq_we, vq_wraddr, vq_wrdata, et); end
      end else if (k < 4) begin
        total++; if ({cpl_ready, vq_we, vq_wraddr, vq_wrdata} !== {1'b1, 1'b1, ord[k], 1'b1})
          begin bad++; $display("FAIL ooo_set[%0d]: got cr=%b we=%b a=%0d d=%b want a=%0d", k, cpl_ready, vq_we, vq_wraddr, vq_wrdata, ord[k]); end
      end
      advance();
      note(1'b0, f);
    end
  endtask

  // Retire of tag 5 blocks a completion to tag 7, which lands the next cycle.
  task automatic test_blocked_cpl();
    logic cv_a [11] = '{0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0};
    tag_t ct_a [11] = '{tag_t'(0), tag_t'(0), tag_t'(0), tag_t'(0), tag_t'(0),
                        tag_t'(7), tag_t'(7), tag_t'(6), tag_t'(0), tag_t'(0), tag_t'(0)};
    logic fi_a [11] = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 1, 1};
    tag_t et;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, '0, 1'b0);
      advance();
      note(1'b1, 1'b0);
    end
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b1, tag_t'(i), 1'b0);
      advance();
    end
    drive(1'b0, 1'b0, '0, 1'b0); advance();
    drive(1'b0, 1'b0, '0, 1'b0); advance();
    for (int k = 0; k < 11; k++) begin
      drive(1'b0, cv_a[k], ct_a[k], 1'b1);
      total++; if (ret_valid !== fi_a[k]) begin bad++; $display("FAIL blk_valid[%0d]: got %b want %b", k, ret_valid, fi_a[k]); end
      total++; if (cpl_ready !== !fi_a[k]) begin bad++; $display("FAIL blk_cpl_ready[%0d]: got %b want %b", k, cpl_ready, !fi_a[k]); end
      if (fi_a[k]) begin
        et = sb.pop_front();
        total++; if (ret_tag !== et) begin bad++; $display("FAIL blk_rtag[%0d]: got %0d want %0d", k, ret_tag, et); end
        total++; if ({vq_we, vq_wraddr, vq_wrdata} !== {1'b1, et, 1'b0})
          begin bad++; $display("FAIL blk_clear[%0d]: got we=%b a=%0d d=%b want a=%0d d=0", k, vq_we, vq_wraddr, vq_wrdata, et); end
      end else if (cv_a[k]) begin
        total++; if ({vq_we, vq_wraddr, vq_wrdata} !== {1'b1, ct_a[k], 1'b1})
          begin bad++; $display("FAIL blk_set[%0d]: got we=%b a=%0d d=%b want a=%0d d=1", k, vq_we, vq_wraddr, vq_wrdata, ct_a[k]); end
      end else begin
        total++; if (vq_we !== 1'b0) begin bad++; $display("FAIL blk_idle_we[%0d]: got %b want 0", k, vq_we); end
      end
      advance();
      note(1'b0, fi_a[k]);
    end
  endtask

  task automatic test_check();
    tag_t et;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, '0, 1'b0);
      advance();
      note(1'b1, 1'b0);
    end
    drive(1'b0, 1'b1, tag_t'(0), 1'b0); advance();
    drive(1'b0, 1'b1, tag_t'(1), 1'b0); advance();
    drive(1'b0, 1'b0, '0, 1'b0); advance();
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 1'b0, '0, 1'b1);
      et = sb.pop_front();
      total++; if ({ret_valid, ret_tag} !== {1'b1, et}) begin bad++; $display("FAIL chk_retire[%0d]: got v=%b t=%0d want v=1 t=%0d", k, ret_valid, ret_tag, et); end
      advance();
      note(1'b0, 1'b1);
    end
    total++; if (cpl_err !== 1'b0) begin bad++; $display("FAIL chk_err_clean: got %b want 0", cpl_err); end
`ifdef REORDER_RETIRE_CTRL_CHECK_EN
    drive(1'b0, 1'b1, tag_t'(9), 1'b0);
    total++; if (cpl_ready !== 1'b1) begin bad++; $display("FAIL chk_bad_ready: got %b want 1", cpl_ready); end
    total++; if (vq_we !== 1'b0) begin bad++; $display("FAIL chk_bad_we: got %b want 0", vq_we); end
    advance();
    drive(1'b0, 1'b1, tag_t'(1), 1'b0);
    total++; if (cpl_err !== 1'b1) begin bad++; $display("FAIL chk_err_set: got %b want 1", cpl_err); end
    total++; if (vq_we !== 1'b0) begin bad++; $display("FAIL chk_stale_we: got %b want 0", vq_we); end
    advance();
    drive(1'b0, 1'b1, tag_t'(3), 1'b0);
    total++; if ({vq_we, vq_wraddr, vq_wrdata} !== {1'b1, tag_t'(3), 1'b1})
      begin bad++; $display("FAIL chk_legal_write: got we=%b a=%0d d=%b want we=1 a=3 d=1", vq_we, vq_wraddr, vq_wrdata); end
    advance();
    for (int c = 0; c < 4; c++) begin
      drive(1'b0, 1'b0, '0, 1'b0);
      total++; if (cpl_err !== 1'b1) begin bad++; $display("FAIL chk_err_sticky[%0d]: got %b want 1", c, cpl_err); end
      advance();
    end
    do_reset();
    drive(1'b0, 1'b0, '0, 1'b0);
    total++; if (cpl_err !== 1'b0) begin bad++; $display("FAIL chk_err_reset: got %b want 0", cpl_err); end
    advance();
`else
    drive(1'b0, 1'b1, tag_t'(3), 1'b0);
    total++; if ({vq_we, vq_wraddr, vq_wrdata} !== {1'b1, tag_t'(3), 1'b1})
      begin bad++; $display("FAIL chk_write: got we=%b a=%0d d=%b want we=1 a=3 d=1", vq_we, vq_wraddr, vq_wrdata); end
    advance();
    drive(1'b0, 1'b0, '0, 1'b0);
    total++; if (cpl_err !== 1'b0) begin bad++; $display("FAIL chk_err_tied: got %b want 0", cpl_err); end
    advance();
`endif
  endtask

  initial begin
    test_reset();
    test_fill();
    test_full_stream();
    test_reset_mid();
    test_out_of_order();
    test_blocked_cpl();
    test_check();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
